// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: finds full rows of the playfield, scanning from the bottom
// row upward, and collapses each one by strobing 'advance' on that row and on
// every row above it. The scan runs once per start pulse. The controller then
// reports the number of rows it removed.
module line_clear_ctrl #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   occ_flat,
  output logic [ROWS-1:0]        advance,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       lines_cleared
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [RW-1:0]      r_row;
  logic [CNT_W-1:0]   r_count;
  logic [ROWS-1:0]    r_advance;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_lines_cleared;

  logic [IW-1:0]      w_base;
  logic               w_row_full;
  logic [ROWS-1:0]    w_mask;

  // Bit offset of the row under the pointer and its full/not-full status.
  assign w_base     = IW'(r_row) * IW'(COLS);
  assign w_row_full = &occ_flat[w_base +: COLS];

  // Advance mask covering the pointed row and every row above it.
  always_comb begin
    // NOTE: defaulting every always_comb output before any branch keeps the
    // block free of inferred latches.
    w_mask = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (RW'(k) <= r_row) begin
        w_mask[k] = 1'b1;
      end
    end
  end

  // Scan/shift controller; every output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_row           <= ROW_LAST;
      r_count         <= '0;
      r_advance       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_lines_cleared <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every branch
      // below reads the values from before this clock edge.
      r_advance <= '0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SCAN;
            r_row   <= ROW_LAST;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_row_full) begin
            r_advance <= w_mask;
            r_state   <= S_SHIFT;
          end else if (r_row != '0) begin
            r_row <= r_row - RW'(1);
          end else begin
            r_state         <= S_DONE;
            r_done          <= 1'b1;
            r_lines_cleared <= r_count;
          end
        end
        S_SHIFT: begin
          // The rows drop into place at the end of this cycle. The same row
          // is then scanned again, because a full row may have moved into it.
          if (r_count != CNT_MAX) begin
            r_count <= r_count + CNT_W'(1);
          end
          r_state <= S_SCAN;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign advance       = r_advance;
  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_cleared = r_lines_cleared;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl. It instantiates a 4x4 board and a 20x10 board.
// The bench itself holds the cell arrays, which honour 'advance'. The reference
// model works from the rules for clearing lines. Full rows disappear and the
// remaining rows settle at the bottom. If n rows below a full row have already
// been removed, that row is cleared when it sits n rows lower than its original
// position. A monitor pops the expected responses from the queues and compares.
module tb_line_clear_ctrl;

  localparam int BW = 200;

  typedef struct {
    int            lc;
    int            cyc;
    logic [BW-1:0] brd;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;

  // 4x4 instance
  logic        a_start, a_load, a_busy, a_done;
  logic [15:0] a_board, a_load_val;
  logic [3:0]  a_adv;
  logic [2:0]  a_lc;
  int          a_win_s = 0, a_win_e = 0;

  // 20x10 instance
  logic         b_start, b_load, b_busy, b_done;
  logic [199:0] b_board, b_load_val;
  logic [19:0]  b_adv;
  logic [4:0]   b_lc;
  int           b_win_s = 0, b_win_e = 0;

  logic [19:0] qa_adv[$], qb_adv[$];
  done_exp_t   qa_done[$], qb_done[$];

  line_clear_ctrl #(.COLS(4), .ROWS(4), .CNT_W(3)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .occ_flat(a_board),
    .advance(a_adv), .busy(a_busy), .done(a_done), .lines_cleared(a_lc)
  );

  line_clear_ctrl #(.COLS(10), .ROWS(20), .CNT_W(5)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .occ_flat(b_board),
    .advance(b_adv), .busy(b_busy), .done(b_done), .lines_cleared(b_lc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell arrays: load from the placer, or move rows down on advance.
  always @(posedge clk) begin
    if (a_load) a_board <= a_load_val;
    else for (int r = 0; r < 4; r++)
      if (a_adv[r]) a_board[r*4 +: 4] <= (r == 0) ? 4'b0 : a_board[(r-1)*4 +: 4];
  end

  always @(posedge clk) begin
    if (b_load) b_board <= b_load_val;
    else for (int r = 0; r < 20; r++)
      if (b_adv[r]) b_board[r*10 +: 10] <= (r == 0) ? 10'b0 : b_board[(r-1)*10 +: 10];
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the surviving rows settle at the bottom. The k-th full
  // row found, scanning upward from original row p, is cleared when it sits
  // at row p+k, so its advance mask covers rows 0..p+k.
  task automatic model(input int rows, input int cols, input logic [BW-1:0] brd,
                       output int n, output logic [BW-1:0] fin, output logic [19:0] masks [20]);
    int  w;
    bit  full;
    n   = 0;
    fin = '0;
    w   = rows - 1;
    for (int i = 0; i < 20; i++) masks[i] = '0;
    for (int p = rows - 1; p >= 0; p--) begin
      full = 1'b1;
      for (int c = 0; c < cols; c++) full &= brd[p*cols+c];
      if (full) begin
        for (int k = 0; k <= p + n; k++) masks[n][k] = 1'b1;
        n++;
      end else begin
        for (int c = 0; c < cols; c++) fin[w*cols+c] = brd[p*cols+c];
        w--;
      end
    end
  endtask

  task automatic issue_a(input logic [15:0] brd);
    int n; logic [BW-1:0] fin; logic [19:0] m [20]; done_exp_t e;
    model(4, 4, BW'(brd), n, fin, m);
    @(negedge clk);
    a_load = 1'b1; a_load_val = brd; a_start = 1'b1;
    for (int i = 0; i < n; i++) qa_adv.push_back(m[i]);
    e.lc = n; e.cyc = cyc + 4 + 1 + 2 * n; e.brd = fin;
    qa_done.push_back(e);
    a_win_s = cyc; a_win_e = e.cyc;
    @(negedge clk);
    a_load = 1'b0; a_start = 1'b0;
  endtask

  task automatic issue_b(input logic [199:0] brd);
    int n; logic [BW-1:0] fin; logic [19:0] m [20]; done_exp_t e;
    model(20, 10, brd, n, fin, m);
    @(negedge clk);
    b_load = 1'b1; b_load_val = brd; b_start = 1'b1;
    for (int i = 0; i < n; i++) qb_adv.push_back(m[i]);
    e.lc = n; e.cyc = cyc + 20 + 1 + 2 * n; e.brd = fin;
    qb_done.push_back(e);
    b_win_s = cyc; b_win_e = e.cyc;
    @(negedge clk);
    b_load = 1'b0; b_start = 1'b0;
  endtask

  // Bounded wait until the monitor has consumed every expected response.
  task automatic wait_drain(input bit is_b);
    for (int i = 0; i < 300; i++) begin
      if (is_b ? (qb_done.size() == 0) : (qa_done.size() == 0)) break;
      @(negedge clk);
    end
    if (is_b ? (qb_done.size() != 0) : (qa_done.size() != 0)) begin
      compared++; failed++;
      $display("FAIL %s_timeout: done not seen within 300 cycles", is_b ? "b" : "a");
      qa_adv.delete(); qa_done.delete(); qb_adv.delete(); qb_done.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin : mon_a
    logic [19:0] em;
    done_exp_t   e;
    if (mon_en) begin
      if (a_adv != '0) begin
        if (qa_adv.size() == 0) begin
          compared++; failed++;
          $display("FAIL a_advance_unexpected: got %b expected none", a_adv);
        end else begin
          em = qa_adv.pop_front();
          check("a_advance", BW'(a_adv), BW'(em));
        end
      end
      if (a_done) begin
        if (qa_done.size() == 0) begin
          compared++; failed++;
          $display("FAIL a_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          e = qa_done.pop_front();
          check("a_lines_cleared", BW'(a_lc), BW'(e.lc));
          check("a_done_cycle", BW'(cyc), BW'(e.cyc));
          check("a_board", BW'(a_board), e.brd);
        end
      end
      check("a_busy", BW'(a_busy), BW'(cyc > a_win_s && cyc <= a_win_e));
    end
  end

  // Monitor for the 20x10 instance.
  always @(negedge clk) begin : mon_b
    logic [19:0] em;
    done_exp_t   e;
    if (mon_en) begin
      if (b_adv != '0) begin
        if (qb_adv.size() == 0) begin
          compared++; failed++;
          $display("FAIL b_advance_unexpected: got %b expected none", b_adv);
        end else begin
          em = qb_adv.pop_front();
          check("b_advance", BW'(b_adv), BW'(em));
        end
      end
      if (b_done) begin
        if (qb_done.size() == 0) begin
          compared++; failed++;
          $display("FAIL b_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          e = qb_done.pop_front();
          check("b_lines_cleared", BW'(b_lc), BW'(e.lc));
          check("b_done_cycle", BW'(cyc), BW'(e.cyc));
          check("b_board", b_board, e.brd);
        end
      end
      check("b_busy", BW'(b_busy), BW'(cyc > b_win_s && cyc <= b_win_e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0]  ra;
    logic [199:0] rb;
    reset = 1'b1;
    a_start = 1'b0; a_load = 1'b0; a_load_val = '0;
    b_start = 1'b0; b_load = 1'b0; b_load_val = '0;
    repeat (3) @(negedge clk);
    check("a_reset_advance", BW'(a_adv), BW'(0));
    check("a_reset_busy", BW'(a_busy), BW'(0));
    check("a_reset_done", BW'(a_done), BW'(0));
    check("a_reset_lc", BW'(a_lc), BW'(0));
    check("b_reset_advance", BW'(b_adv), BW'(0));
    check("b_reset_busy", BW'(b_busy), BW'(0));
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Directed 4x4 boards: empty, bottom full over 0101, rows 1 and 3 full,
    // whole board full, only the top row full.
    issue_a(16'h0000); wait_drain(1'b0);
    issue_a(16'hF500); wait_drain(1'b0);
    issue_a(16'hF6F9); wait_drain(1'b0);
    issue_a(16'hFFFF); wait_drain(1'b0);
    issue_a(16'h000F); wait_drain(1'b0);

    // A second start while busy must be ignored.
    issue_a(16'h0F00);
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_drain(1'b0);

    // Random 4x4 boards, biased toward full rows.
    for (int it = 0; it < 30; it++) begin
      for (int r = 0; r < 4; r++)
        ra[r*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      issue_a(ra); wait_drain(1'b0);
    end

    // 20x10: only the bottom row full, then random boards.
    issue_b({10'h3FF, 190'b0}); wait_drain(1'b1);
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 20; r++)
        rb[r*10 +: 10] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
      issue_b(rb); wait_drain(1'b1);
    end

    // Leave a non-zero count behind, then reset in the middle of a SHIFT.
    issue_a(16'hFFFF); wait_drain(1'b0);
    check("a_queues_drained", BW'(qa_adv.size() + qa_done.size()), BW'(0));
    check("b_queues_drained", BW'(qb_adv.size() + qb_done.size()), BW'(0));
    mon_en = 1'b0;
    @(negedge clk);
    a_load = 1'b1; a_load_val = 16'hF000; a_start = 1'b1;
    @(negedge clk);
    a_load = 1'b0; a_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_adv != '0) break;
      @(negedge clk);
    end
    check("rst_shift_advance", BW'(a_adv), BW'(4'b1111));
    reset = 1'b1;
    #1;
    check("rst_async_advance", BW'(a_adv), BW'(0));
    check("rst_async_busy", BW'(a_busy), BW'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_after_lc", BW'(a_lc), BW'(0));
    check("rst_after_busy", BW'(a_busy), BW'(0));
    check("rst_after_done", BW'(a_done), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
